cache_fill_ctrl: RTL and testbench
==================================

// Module: cache_fill_ctrl
// PURPOSE
//  Miss-fill controller for the 2-way data cache (64 sets x 8 words x 16b).
//  On a miss it fetches the 8-word block from pipelined main memory.
//  It writes each returned word into the data array, then writes the metadata (tag) array once.
//  Sits between the cache hit/miss logic and the memory port.
// PARAMETERS
//  ADDR_W   16  byte-address width
//  DATA_W   16  word width (2 bytes/word)
//  WORDS     8  words per block; block = 16 bytes, base = addr & ~16'h000F
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       synchronous reset, active-low (rst==0 at edge resets)
//  miss_detected  in   1       cache miss this cycle (level, sampled in IDLE only)
//  miss_address   in   ADDR_W  byte address of missing access
//  mem_data_in    in   DATA_W  word returned by memory
//  mem_data_valid in   1       mem_data_in valid this cycle (in issue order)
//  fsm_busy       out  1       fill in progress; stalls pipeline
//  mem_read       out  1       memory read request this cycle
//  mem_address    out  ADDR_W  address for mem_read
//  data_write     out  1       write fill_data into data array this cycle
//  word_en        out  WORDS   one-hot word select for data_write
//  fill_data      out  DATA_W  word to write (= mem_data_in)
//  tag_write      out  1       write metadata array this cycle (1 cycle)
// BEHAVIOUR
//  State:
//   - FSM states IDLE, FILL, TAG
//   - regs: base[ADDR_W-1:4], issue_cnt[3:0], recv_cnt[3:0]
//  Reset:
//   - state=IDLE, counters=0, base=0
//   - all outputs 0, including mem_address, word_en and fill_data
//   - reset mid-fill aborts immediately; data still in flight is ignored
//     (valid is not accepted in IDLE)
//  IDLE:
//   - all outputs 0
//   - miss_detected=1 at edge: latch base=miss_address[15:4], clear counters, go to FILL
//  FILL:
//   - fsm_busy=1
//   - issue: mem_read=1 while issue_cnt<8
//     - mem_address = {base,4'b0} + 2*issue_cnt
//     - issue_cnt++ each cycle; 8 consecutive cycles, no gaps
//     - mem_address=0 once issue_cnt==8
//   - receive: data_write = mem_data_valid && recv_cnt<8 (combinational)
//     - word_en = 1<<recv_cnt
//     - fill_data = mem_data_in
//     - recv_cnt++ on each accepted word
//   - memory latency is arbitrary (>=1); the controller only counts
//     - valid may coincide with an issue cycle; both proceed in the same cycle
//   - valid while recv_cnt==8 is ignored
//   - valid before any issue cannot occur (protocol); it is accepted anyway
//   - 8th word accepted: next state is TAG
//  TAG:
//   - fsm_busy=1, tag_write=1 for exactly one cycle, then IDLE
//   - metadata content (tag/valid/LRU) is formed externally
//  Miss handling:
//   - miss_detected is ignored outside IDLE
//   - miss_detected held high after TAG starts a new fill (caller drops it on refill hit)
//  Latency: miss edge to tag_write = 8 + L cycles for memory latency L (pipelined)
//  Counters saturate at 8; no wrap. Address add is ADDR_W-bit, no carry into tag (block-aligned).
// TESTING
//  1. Reset with rst=0, 3 cycles -> every output 0, state IDLE.
//  2. Fill, memory latency L=4:
//     - stimulus: miss_address=16'h1236; memory returns 16'hA000+i
//     - mem_read high 8 cycles with addresses 16'h1230,1232,...,123E
//     - data_write pulses 8x, word_en 01..80, fill_data A000..A007
//     - one tag_write, then fsm_busy=0; total 8+4+1 cycles
//  3. Gapped returns: valid with 2-cycle gaps
//     - exactly 8 data_writes in order
//     - tag_write comes only after the 8th; fsm_busy stays high throughout
//  4. Extra valid pulse after 8th word, and miss_detected pulsed during FILL
//     -> no 9th data_write; no restart and base unchanged
//  5. Reset mid-fill after 3 words -> IDLE next cycle
//     - the remaining valids are ignored
//     - a new miss at 16'h00F0 issues from 16'h00F0
//  6. Back-to-back: miss_detected held high -> second fill starts the cycle after tag_write

Source files
------------

// File: rtl/cache_fill_ctrl.sv
// Miss-fill controller for a 2-way data cache (64 sets x 8 words x 16b).
// On a miss it issues eight pipelined word reads for the missing block.
// Each returned word is written into the data array in issue order.
// A single metadata (tag) write follows once all eight words are in.
//
// Handshake: memory has no ready/back-pressure. A read is issued in every
// cycle that mem_read=1. A word is consumed in every cycle that
// mem_data_valid=1, but only while the controller is in FILL and still owes
// words. Any other valid cycle is dropped, so nothing a stale fill returns
// after a reset ever reaches the data array.
module cache_fill_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_data_valid,
    output logic              fsm_busy,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic              data_write,
    output logic [WORDS-1:0]  word_en,
    output logic [DATA_W-1:0] fill_data,
    output logic              tag_write,
    output logic [1:0]        dbgState
);

    // Byte-offset bits of a word and of a whole block
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int OFF_W   = $clog2(WORDS) + BYTE_SH;
    localparam int CNT_W   = $clog2(WORDS) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        TAG  = 2'd2
    } stateT;

    stateT                   state;
    stateT                   nextState;
    logic [ADDR_W-OFF_W-1:0] base;
    logic [CNT_W-1:0]        issueCnt;
    logic [CNT_W-1:0]        recvCnt;
    logic                    issueActive;
    logic                    acceptWord;
    logic                    lastWord;

    // Offset bits of the miss address are irrelevant: fills are block-aligned
    logic unusedBits;
    assign unusedBits = ^miss_address[OFF_W-1:0];

    // Issue and accept qualifiers shared by the counters and the outputs
    always_comb begin
        issueActive = (state == FILL) && (issueCnt < CNT_FULL);
        acceptWord  = (state == FILL) && mem_data_valid && (recvCnt < CNT_FULL);
        lastWord    = acceptWord && (recvCnt == CNT_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Block base and issue/receive counters; counters stop at WORDS
    always_ff @(posedge clk) begin
        if (!rst) begin
            base     <= '0;
            issueCnt <= '0;
            recvCnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_detected) begin
                        base     <= miss_address[ADDR_W-1:OFF_W];
                        issueCnt <= '0;
                        recvCnt  <= '0;
                    end
                end
                FILL: begin
                    if (issueActive) begin
                        issueCnt <= issueCnt + 1'b1;
                    end
                    if (acceptWord) begin
                        recvCnt <= recvCnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state: miss only looked at in IDLE; TAG lasts exactly one cycle
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (miss_detected) nextState = FILL;
            FILL:    if (lastWord) nextState = TAG;
            TAG:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs: everything zero outside the states that drive it
    always_comb begin
        fsm_busy    = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;
        data_write  = 1'b0;
        word_en     = '0;
        fill_data   = '0;
        tag_write   = 1'b0;
        case (state)
            FILL: begin
                fsm_busy   = 1'b1;
                mem_read   = issueActive;
                if (issueActive) begin
                    mem_address = {base, {OFF_W{1'b0}}} + (ADDR_W'(issueCnt) << BYTE_SH);
                end
                data_write = acceptWord;
                if (acceptWord) begin
                    word_en = WORDS'(1) << recvCnt;
                end
                fill_data  = mem_data_in;
            end
            TAG: begin
                fsm_busy  = 1'b1;
                tag_write = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dbgState = state;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: a vector table for the latency-4 fill, then
// hand-written sequences driving a small in-order memory model.
module tb_cache_fill_ctrl;

    logic        clk;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic [15:0] mem_data_in;
    logic        mem_data_valid;
    logic        fsm_busy;
    logic        mem_read;
    logic [15:0] mem_address;
    logic        data_write;
    logic [7:0]  word_en;
    logic [15:0] fill_data;
    logic        tag_write;
    logic [1:0]  dbgState;

    int total = 0;
    int bad   = 0;

    cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORDS(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .miss_detected  (miss_detected),
        .miss_address   (miss_address),
        .mem_data_in    (mem_data_in),
        .mem_data_valid (mem_data_valid),
        .fsm_busy       (fsm_busy),
        .mem_read       (mem_read),
        .mem_address    (mem_address),
        .data_write     (data_write),
        .word_en        (word_en),
        .fill_data      (fill_data),
        .tag_write      (tag_write),
        .dbgState       (dbgState)
    );

    // Clock and global time limit
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1, "timeout");
    end

    // Driver tasks: inputs change 1 time unit after the rising edge,
    // outputs are sampled on the falling edge.
    task automatic drive(input logic m, input logic [15:0] a, input logic v, input logic [15:0] d);
        miss_detected  = m;
        miss_address   = a;
        mem_data_valid = v;
        mem_data_in    = d;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkIdleOutputs(input string tag);
        chk({tag, "_busy"}, fsm_busy, 0);
        chk({tag, "_read"}, mem_read, 0);
        chk({tag, "_addr"}, mem_address, 0);
        chk({tag, "_dwrite"}, data_write, 0);
        chk({tag, "_wen"}, word_en, 0);
        chk({tag, "_fdata"}, fill_data, 0);
        chk({tag, "_tag"}, tag_write, 0);
    endtask

    // One complete fill against an in-order memory model.
    // lat: cycles from issue to earliest return; gap: idle cycles forced
    // between returns; extra: two spurious valids after the 8th word;
    // missPulse: a miss to another block in the 4th fill cycle; holdMiss:
    // miss stays high and the trailing idle cycle is left to the caller.
    task automatic runFill(input logic [15:0] addr, input int lat, input int gap,
                           input bit extra, input bit missPulse, input bit holdMiss,
                           input int expTag);
        logic [15:0] baseA;
        logic [15:0] retData[$];
        int          retDue[$];
        logic [23:0] expQ[$];
        logic [23:0] e;
        int          issued, recvd, cyc, tagCyc, nextOk, extraLeft;
        bit          done, tagPending, isExtra;
        logic        v, m;
        logic [15:0] d, ma;

        baseA = addr & 16'hFFF0;
        issued = 0; recvd = 0; tagCyc = -1; nextOk = 0;
        extraLeft = extra ? 2 : 0;
        done = 0; tagPending = 0;

        // Miss presented while IDLE
        drive(1'b1, addr, 1'b0, 16'h0);
        sample();
        chk("miss_cycle_busy", fsm_busy, 0);
        chk("miss_cycle_read", mem_read, 0);
        advance();

        cyc = 0;
        while (!done && cyc < 80) begin
            v = 1'b0; d = 16'h0; isExtra = 0;
            if (retDue.size() > 0 && retDue[0] <= cyc && cyc >= nextOk) begin
                v = 1'b1;
                d = retData.pop_front();
                void'(retDue.pop_front());
                nextOk = cyc + gap + 1;
            end else if (recvd == 8 && extraLeft > 0) begin
                v = 1'b1; d = 16'hDEAD; isExtra = 1; extraLeft--;
            end
            m  = holdMiss || (missPulse && cyc == 3);
            ma = (missPulse && cyc == 3) ? 16'h4440 : addr;
            drive(m, ma, v, d);
            sample();

            chk("fill_busy", fsm_busy, 1);
            chk("fill_read", mem_read, (cyc < 8) ? 1 : 0);
            if (mem_read) begin
                chk("fill_addr", mem_address, 16'(baseA + 16'(2 * issued)));
                retDue.push_back(cyc + lat);
                retData.push_back(16'hA000 + 16'(issued));
                expQ.push_back({8'(1 << issued), 16'hA000 + 16'(issued)});
                issued++;
            end else begin
                chk("fill_addr_zero", mem_address, 0);
            end

            chk("fill_dwrite", data_write, (v && !isExtra) ? 1 : 0);
            if (data_write) begin
                if (expQ.size() == 0) begin
                    chk("fill_word_unexpected", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    chk("fill_wen", word_en, e[23:16]);
                    chk("fill_data", fill_data, e[15:0]);
                end
                recvd++;
            end

            chk("fill_tag", tag_write, tagPending ? 1 : 0);
            if (tagPending) begin
                tagCyc = cyc;
                done = 1;
            end
            if (data_write && recvd == 8) tagPending = 1;
            advance();
            cyc++;
        end
        chk("tag_cycle", tagCyc, expTag);
        chk("words_received", recvd, 8);

        if (!holdMiss) begin
            drive(1'b0, addr, extraLeft > 0, 16'hDEAD);
            sample();
            chkIdleOutputs("after_tag");
            advance();
        end
    endtask

    typedef struct {
        logic        miss;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] din;
        logic        busy;
        logic        rd;
        logic [15:0] maddr;
        logic        dw;
        logic [7:0]  wen;
        logic [15:0] fd;
        logic        tw;
    } vecT;

    vecT vecs[15];

    initial begin
        // Vector table: miss at 16'h1236, memory latency 4, data A000+i.
        // Row 0 is the IDLE cycle with the miss, rows 1..13 busy, row 14 idle.
        for (int r = 0; r < 15; r++) begin
            vecs[r] = '{miss: 1'b0, addr: 16'h1236, valid: 1'b0, din: 16'h0,
                        busy: 1'b0, rd: 1'b0, maddr: 16'h0, dw: 1'b0,
                        wen: 8'h0, fd: 16'h0, tw: 1'b0};
            if (r == 0) vecs[r].miss = 1'b1;
            if (r >= 1 && r <= 13) vecs[r].busy = 1'b1;
            if (r >= 1 && r <= 8) begin
                vecs[r].rd    = 1'b1;
                vecs[r].maddr = 16'h1230 + 16'(2 * (r - 1));
            end
            if (r >= 5 && r <= 12) begin
                vecs[r].valid = 1'b1;
                vecs[r].din   = 16'hA000 + 16'(r - 5);
                vecs[r].dw    = 1'b1;
                vecs[r].wen   = 8'(1 << (r - 5));
                vecs[r].fd    = 16'hA000 + 16'(r - 5);
            end
            if (r == 13) vecs[r].tw = 1'b1;
        end

        // Reset: 3 cycles with rst low while other inputs are active
        rst = 1'b0;
        drive(1'b1, 16'h5555, 1'b1, 16'hBEEF);
        for (int i = 0; i < 3; i++) begin
            advance();
            sample();
            chkIdleOutputs("reset");
            chk("reset_state", dbgState, 0);
        end
        advance();
        rst = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 16'h0);
        advance();

        // Fill with latency 4 from the table
        for (int r = 0; r < 15; r++) begin
            drive(vecs[r].miss, vecs[r].addr, vecs[r].valid, vecs[r].din);
            sample();
            chk("vec_busy", fsm_busy, vecs[r].busy);
            chk("vec_read", mem_read, vecs[r].rd);
            chk("vec_addr", mem_address, vecs[r].maddr);
            chk("vec_dwrite", data_write, vecs[r].dw);
            chk("vec_tag", tag_write, vecs[r].tw);
            if (vecs[r].dw || !vecs[r].busy) begin
                chk("vec_wen", word_en, vecs[r].wen);
                chk("vec_fdata", fill_data, vecs[r].fd);
            end
            advance();
        end

        // Gapped returns: latency 2, two idle cycles between words
        runFill(16'h3A5C, 2, 2, 1'b0, 1'b0, 1'b0, 24);

        // Extra valids after the 8th word, and a miss pulse mid-fill
        runFill(16'h7F02, 3, 0, 1'b1, 1'b1, 1'b0, 11);

        // Reset after three words of a latency-1 fill
        drive(1'b1, 16'h2000, 1'b0, 16'h0);
        sample();
        chk("abort_miss_busy", fsm_busy, 0);
        advance();
        drive(1'b0, 16'h2000, 1'b0, 16'h0);
        sample();
        chk("abort_first_addr", mem_address, 16'h2000);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 16'h2000, 1'b1, 16'hA000 + 16'(i));
            sample();
            chk("abort_dwrite", data_write, 1);
            chk("abort_wen", word_en, 8'(1 << i));
            chk("abort_fdata", fill_data, 16'hA000 + 16'(i));
            advance();
        end
        rst = 1'b0;
        drive(1'b0, 16'h2000, 1'b0, 16'h0);
        sample();
        chk("abort_busy_before_edge", fsm_busy, 1);
        advance();
        rst = 1'b1;
        for (int i = 3; i < 6; i++) begin
            drive(1'b0, 16'h2000, 1'b1, 16'hA000 + 16'(i));
            sample();
            chkIdleOutputs("abort_stale");
            chk("abort_state", dbgState, 0);
            advance();
        end
        runFill(16'h00F0, 1, 0, 1'b0, 1'b0, 1'b0, 9);

        // Back-to-back: miss held high across two fills
        runFill(16'hC468, 1, 0, 1'b0, 1'b0, 1'b1, 9);
        runFill(16'hC468, 1, 0, 1'b0, 1'b0, 1'b0, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
